// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: widths, state codes, opcodes,
// ALU control codes and ALU B-source encodings.
package mc_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned SRCB_W  = 2;

  localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] S_WB     = 3'd3;
  localparam logic [STATE_W-1:0] S_BRANCH = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NAND = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0111;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BNE  = 4'b1001;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [ALUC_W-1:0] ALU_NAND = 4'b1101;

  localparam logic [SRCB_W-1:0] SRCB_RD2     = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_TWO     = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_SEXT    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_SEXT_SH = 2'b11;

  // Opcodes 0000-0111 are the register/immediate ALU group that runs EXEC+WB.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return ~op[OP_W-1];
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode map to ALU control, ALU B-source and destination select
// for the EXEC and WB states.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  output logic [ALUC_W-1:0] alu_control_c,
  output logic [SRCB_W-1:0] alu_src_b_c,
  output logic              reg_dst_c
);

  always_comb begin
    alu_control_c = ALU_ADD;
    alu_src_b_c   = SRCB_RD2;
    reg_dst_c     = 1'b1;
    case (op)
      OP_ADD:  alu_control_c = ALU_ADD;
      OP_SUB:  alu_control_c = ALU_SUB;
      OP_AND:  alu_control_c = ALU_AND;
      OP_OR:   alu_control_c = ALU_OR;
      OP_NOR:  alu_control_c = ALU_NOR;
      OP_NAND: alu_control_c = ALU_NAND;
      OP_SLT:  alu_control_c = ALU_SLT;
      OP_ADDI: begin
        alu_control_c = ALU_ADD;
        alu_src_b_c   = SRCB_SEXT;
        reg_dst_c     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer with imem handshake, halt and
// retired-instruction counter. Define MULTICYCLE_CONTROLLER_BRANCH_EN to build in BEQ/BNE.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               imem_ack,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               target_write,
  output logic               alu_src_a,
  output logic [SRCB_W-1:0]  alu_src_b,
  output logic [ALUC_W-1:0]  alu_control,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               halted,
  output logic [STATE_W-1:0] state,
  output logic [DATA_W-1:0]  instr_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  count_q;
  logic               count_inc_c;

  logic               imem_req_c, ir_write_c, pc_write_c, pc_src_c, target_write_c;
  logic               alu_src_a_c, reg_dst_c, reg_write_c, halted_c;
  logic [SRCB_W-1:0]  alu_src_b_c;
  logic [ALUC_W-1:0]  alu_control_c;

  logic [ALUC_W-1:0]  dec_alu_control_c;
  logic [SRCB_W-1:0]  dec_alu_src_b_c;
  logic               dec_reg_dst_c;

  mc_alu_decode u_alu_decode (
    .op            (op),
    .alu_control_c (dec_alu_control_c),
    .alu_src_b_c   (dec_alu_src_b_c),
    .reg_dst_c     (dec_reg_dst_c)
  );

`ifdef MULTICYCLE_CONTROLLER_BRANCH_EN
  logic branch_taken_c;
  assign branch_taken_c = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
`else
  logic unused_zero;
  assign unused_zero = zero;
`endif

  // Next state and per-state control.
  always_comb begin
    state_d        = state_q;
    count_inc_c    = 1'b0;
    imem_req_c     = 1'b0;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 1'b0;
    target_write_c = 1'b0;
    alu_src_a_c    = 1'b0;
    alu_src_b_c    = SRCB_RD2;
    alu_control_c  = ALU_AND;
    reg_dst_c      = 1'b0;
    reg_write_c    = 1'b0;
    halted_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c    = 1'b1;
        alu_src_b_c   = SRCB_TWO;
        alu_control_c = ALU_ADD;
        if (imem_ack) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target = incremented PC + (sext << 1), captured speculatively.
        alu_src_b_c   = SRCB_SEXT_SH;
        alu_control_c = ALU_ADD;
`ifdef MULTICYCLE_CONTROLLER_BRANCH_EN
        target_write_c = 1'b1;
`endif
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end
`ifdef MULTICYCLE_CONTROLLER_BRANCH_EN
        else if ((op == OP_BEQ) || (op == OP_BNE)) begin
          state_d = S_BRANCH;
        end
`endif
        else if (is_alu_op(op)) begin
          state_d = S_EXEC;
        end else begin
          state_d     = S_FETCH;
          count_inc_c = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = dec_alu_src_b_c;
        alu_control_c = dec_alu_control_c;
        reg_dst_c     = dec_reg_dst_c;
        state_d       = S_WB;
      end
      S_WB: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = dec_alu_src_b_c;
        alu_control_c = dec_alu_control_c;
        reg_dst_c     = dec_reg_dst_c;
        reg_write_c   = 1'b1;
        count_inc_c   = 1'b1;
        state_d       = S_FETCH;
      end
`ifdef MULTICYCLE_CONTROLLER_BRANCH_EN
      S_BRANCH: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = SRCB_RD2;
        alu_control_c = ALU_SUB;
        pc_write_c    = branch_taken_c;
        pc_src_c      = branch_taken_c;
        count_inc_c   = 1'b1;
        state_d       = S_FETCH;
      end
`endif
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (count_inc_c) count_q <= count_q + DATA_W'(1);
    end
  end

  // Controls are forced low while reset is held so a pending write is dropped at once.
  assign imem_req     = resetn & imem_req_c;
  assign ir_write     = resetn & ir_write_c;
  assign pc_write     = resetn & pc_write_c;
  assign pc_src       = resetn & pc_src_c;
  assign target_write = resetn & target_write_c;
  assign alu_src_a    = resetn & alu_src_a_c;
  assign alu_src_b    = resetn ? alu_src_b_c : '0;
  assign alu_control  = resetn ? alu_control_c : '0;
  assign reg_dst      = resetn & reg_dst_c;
  assign reg_write    = resetn & reg_write_c;
  assign halted       = resetn & halted_c;
  assign state        = state_q;
  assign instr_count  = count_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencing FSM for the 16-bit, 4-register datapath. It replaces single-cycle control by stepping each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, so one ALU serves both PC increment and execution. It handshakes with instruction memory, halts on opcode 4'b1111 and counts retired instructions. It sits between the instruction register / opcode field and the datapath mux selects, write enables and ALU control.

## Interface
- No parameters. Datapath width is fixed at 16 bits and opcode width at 4 bits, both taken from the shared package.
- clock  input  1  rising-edge clock for all state
- resetn  input  1  asynchronous, active-low reset
- imem_ack  input  1  instruction memory has valid data this cycle
- op  input  4  opcode, IR[15:12], from the externally latched IR
- zero  input  1  ALU Zero flag
- imem_req  output  1  fetch request to instruction memory
- ir_write  output  1  load IR from memory data
- pc_write  output  1  load PC from the PC source mux
- pc_src  output  1  0 = ALU result, 1 = branch target register
- target_write  output  1  load branch target register from ALU result
- alu_src_a  output  1  0 = PC, 1 = RD1
- alu_src_b  output  2  00 = RD2, 01 = constant 2, 10 = sign-extend, 11 = sign-extend << 1
- alu_control  output  4  ALU code: add 0010, sub 0110, and 0000, or 0001, nor 1100, nand 1101, slt 0111
- reg_dst  output  1  1 = IR[7:6], 0 = IR[9:8]
- reg_write  output  1  register file write enable
- halted  output  1  sticky halt indicator
- state  output  3  current state code, for debug
- instr_count  output  16  retired-instruction counter

## Operation
States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, WB = 3, BRANCH = 4, HALT = 5.

- **FETCH**
  - Drive imem_req = 1, alu_src_a = 0, alu_src_b = 01, alu_control = add.
  - While imem_ack = 0, hold in FETCH.
  - On imem_ack = 1: assert ir_write = 1 and pc_write = 1 (pc_src = 0), go to DECODE.
- **DECODE**
  - alu_src_a = 0, alu_src_b = 11, alu_control = add, target_write = 1. This uses the already-incremented PC.
  - op = 1111 → HALT.
  - op = 1000/1001 → BRANCH when the branch feature is built in (see Configuration).
  - op 0000–0111 → EXEC.
  - Any other op → FETCH as a NOP, with no write and the instruction counted.
- **EXEC**
  - alu_src_a = 1.
  - Opcodes 0000–0110: alu_src_b = 00, reg_dst = 1, with alu_control per opcode:
    - 0000 = add
    - 0001 = sub
    - 0010 = and
    - 0011 = or
    - 0100 = nor
    - 0101 = nand
    - 0110 = slt
  - Opcode 0111 (addi): alu_src_b = 10, reg_dst = 0, alu_control = add.
  - Always → WB.
- **WB**
  - Same mux and ALU selects as EXEC, plus reg_write = 1.
  - Increment instr_count, then → FETCH.
- **BRANCH**
  - alu_src_a = 1, alu_src_b = 00, alu_control = sub.
  - pc_write = 1 with pc_src = 1 when (op = 1000 and zero = 1) or (op = 1001 and zero = 0).
  - Increment instr_count, then → FETCH.
- **HALT**
  - halted = 1. All write enables and imem_req are 0.
  - Remains in HALT until resetn is asserted.
  - The halt instruction itself is not counted.

Other rules:
- op is sampled combinationally. The IR is stable from the end of FETCH until the next FETCH.
- Any output not listed for a state is 0.

## Timing
- Reset (asynchronous, active-low):
  - Takes effect immediately, including mid-instruction or mid-handshake.
  - Forces state = FETCH and instr_count = 0.
  - With resetn low, every output is 0, including imem_req. state reads 0, which is FETCH.
  - A write in progress is dropped. WB's reg_write is combinational and falls as soon as reset asserts.
- Latency with zero memory wait (imem_ack high on the first FETCH cycle):
  - R-type and addi: 4 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
  - Each cycle imem_ack is low adds one cycle.
- imem_req is held high and stable until ack arrives. An ack while not in FETCH is ignored.
- instr_count wraps from 0xFFFF to 0x0000.
- The enable outputs depend on state and, in DECODE/EXEC/WB/BRANCH, on op or zero.

## Configuration
- Macro: MULTICYCLE_CONTROLLER_BRANCH_EN.
- Defined: the BRANCH state, the target_write behaviour in DECODE, and pc_src = 1 paths all exist.
- Undefined:
  - Opcodes 1000/1001 decode as NOP.
  - pc_src and target_write are tied to 0.
  - The BRANCH state code is unused.

## Structure
- Shared package mc_pkg holds:
  - state enum/localparams
  - opcode constants (OP_ADD … OP_ADDI, OP_BEQ, OP_BNE, OP_HALT)
  - ALU control codes
  - alu_src_b encodings
- One sub-module, mc_alu_decode: a combinational map op → {alu_control, alu_src_b, reg_dst} used by EXEC and WB.
- The FSM register and instr_count live in multicycle_controller.

## Test plan
- **Reset:** hold resetn low 3 cycles, then release.
  - Expect state = 0 and all outputs 0 while low.
  - First FETCH cycle after release: imem_req = 1.
- **addi, no wait:** op = 0111 with ack always 1.
  - Expect states 0, 1, 2, 3.
  - In WB: reg_write = 1, alu_src_b = 10, reg_dst = 0.
  - instr_count = 1 afterwards.
- **Memory wait:** op = 0000 with ack low for 3 cycles.
  - Expect FETCH held 4 cycles and ir_write asserted only on the ack cycle.
  - Total 7 cycles to return to FETCH.
- **Branch (macro defined):**
  - op = 1000, zero = 1 → pc_write = 1 and pc_src = 1 in BRANCH.
  - op = 1001, zero = 1 → pc_write = 0.
- **Halt:** op = 1111.
  - Expect halted = 1 and state = 5 for 10 or more cycles.
  - No further imem_req; instr_count unchanged.
- **Reset mid-WB and counter wrap:**
  - Assert resetn low in WB → reg_write drops immediately and state = 0.
  - Preload via 65536 NOPs → instr_count wraps to 0.
